// File: rtl/qpsk_carrier_sequencer.sv
// QPSK symbol-rate sequencer: per-sample sine/cosine table addresses and channel signs.
// Optional QPSK_SYM_COUNT_EN adds a 16-bit accepted-symbol counter output.
module qpsk_carrier_sequencer #(
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned PERIODS_PER_SYM = 2,
    parameter int unsigned QUAD_OFFSET     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_underrun,
    input  logic [1:0]        sym_data,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [ADDR_W-1:0] q_addr,
    output logic [ADDR_W-1:0] i_addr,
    output logic              i_neg,
    output logic              q_neg,
    output logic              carrier_valid,
    output logic              sym_start,
    output logic              busy,
    output logic              underrun
`ifdef QPSK_SYM_COUNT_EN
    ,
    output logic [15:0]       sym_count
`endif
);

    localparam int unsigned SYM_LEN = PERIODS_PER_SYM * (2 ** ADDR_W);
    localparam int unsigned CNT_W   = $clog2(SYM_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SYM_LEN - 1);
    localparam logic [ADDR_W-1:0] I_OFS    = ADDR_W'(QUAD_OFFSET);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] phase_q, phase_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              i_neg_q, i_neg_d;
    logic              q_neg_q, q_neg_d;
    logic              cv_q, cv_d;
    logic              sym_start_q, sym_start_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              last_c;
    logic              accept_c;
`ifdef QPSK_SYM_COUNT_EN
    logic [15:0]       sym_count_q, sym_count_d;
`endif

    // Ready only when idle or on the final sample of the current symbol.
    always_comb begin
        last_c    = (state_q == S_RUN) && (cnt_q == LAST_CNT);
        sym_ready = enable && ((state_q == S_IDLE) || last_c);
        accept_c  = sym_valid && sym_ready;
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + ADDR_W'(1);
        cnt_d       = cnt_q + CNT_W'(1);
        i_neg_d     = i_neg_q;
        q_neg_d     = q_neg_q;
        cv_d        = cv_q;
        sym_start_d = 1'b0;
        underrun_d  = underrun_q;

        if (clear_underrun) begin
            underrun_d = 1'b0;
        end

        if (accept_c) begin
            state_d     = S_RUN;
            phase_d     = '0;
            cnt_d       = '0;
            i_neg_d     = sym_data[1];
            q_neg_d     = sym_data[0];
            cv_d        = 1'b1;
            sym_start_d = 1'b1;
        end else if ((state_q == S_IDLE) || last_c) begin
            state_d = S_IDLE;
            phase_d = '0;
            cnt_d   = '0;
            i_neg_d = 1'b0;
            q_neg_d = 1'b0;
            cv_d    = 1'b0;
            // Starved while enabled sets the flag; wins over a same-cycle clear.
            if (last_c && enable) begin
                underrun_d = 1'b1;
            end
        end

        i_addr_d = phase_d + I_OFS;
        busy_d   = (state_d == S_RUN);
    end

`ifdef QPSK_SYM_COUNT_EN
    always_comb begin
        sym_count_d = clear_underrun ? 16'd0 : sym_count_q;
        if (accept_c) begin
            sym_count_d = sym_count_d + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            i_addr_q    <= I_OFS;
            cnt_q       <= '0;
            i_neg_q     <= 1'b0;
            q_neg_q     <= 1'b0;
            cv_q        <= 1'b0;
            sym_start_q <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef QPSK_SYM_COUNT_EN
            sym_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            i_addr_q    <= i_addr_d;
            cnt_q       <= cnt_d;
            i_neg_q     <= i_neg_d;
            q_neg_q     <= q_neg_d;
            cv_q        <= cv_d;
            sym_start_q <= sym_start_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
`ifdef QPSK_SYM_COUNT_EN
            sym_count_q <= sym_count_d;
`endif
        end
    end

    assign q_addr        = phase_q;
    assign i_addr        = i_addr_q;
    assign i_neg         = i_neg_q;
    assign q_neg         = q_neg_q;
    assign carrier_valid = cv_q;
    assign sym_start     = sym_start_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;
`ifdef QPSK_SYM_COUNT_EN
    assign sym_count     = sym_count_q;
`endif

endmodule

// File: tb/tb_qpsk_carrier_sequencer.sv
// Directed self-checking bench for qpsk_carrier_sequencer (QPSK_SYM_COUNT_EN optional).
module tb_qpsk_carrier_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear_underrun;
    logic [1:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;
    logic [3:0] q_addr;
    logic [3:0] i_addr;
    logic       i_neg;
    logic       q_neg;
    logic       carrier_valid;
    logic       sym_start;
    logic       busy;
    logic       underrun;
`ifdef QPSK_SYM_COUNT_EN
    logic [15:0] sym_count;
`endif

    int checks = 0;
    int passes = 0;

    // {q_addr, i_addr, i_neg, q_neg, carrier_valid, sym_start, busy, sym_ready, underrun}
    logic [14:0] obs;
    assign obs = {q_addr, i_addr, i_neg, q_neg, carrier_valid, sym_start, busy, sym_ready, underrun};

    qpsk_carrier_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .clear_underrun (clear_underrun),
        .sym_data       (sym_data),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .q_addr         (q_addr),
        .i_addr         (i_addr),
        .i_neg          (i_neg),
        .q_neg          (q_neg),
        .carrier_valid  (carrier_valid),
        .sym_start      (sym_start),
        .busy           (busy),
        .underrun       (underrun)
`ifdef QPSK_SYM_COUNT_EN
        ,
        .sym_count      (sym_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [14:0] exp;
        repeat (2) step();
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) $display("FAIL reset_state obs=%h exp=%h", obs, exp);
        else passes++;
`ifdef QPSK_SYM_COUNT_EN
        checks++;
        if (sym_count !== 16'd0) $display("FAIL reset_sym_count got=%0d exp=0", sym_count);
        else passes++;
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single;
        logic [14:0] exp;
        enable    = 1'b1;
        sym_data  = 2'b10;
        sym_valid = 1'b1;
        #1;
        checks++;
        if (sym_ready !== 1'b1) $display("FAIL single_idle_ready got=%b exp=1", sym_ready);
        else passes++;
        step();
        sym_valid = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp = {4'(n), 4'(n + 4), 1'b1, 1'b0, 1'b1, (n == 0), 1'b1, (n == 31), 1'b0};
            checks++;
            if (obs !== exp) $display("FAIL single_sample%0d obs=%h exp=%h", n, obs, exp);
            else passes++;
            step();
        end
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) $display("FAIL single_end_idle obs=%h exp=%h", obs, exp);
        else passes++;
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) $display("FAIL single_clear got=%b exp=0", underrun);
        else passes++;
`ifdef QPSK_SYM_COUNT_EN
        checks++;
        if (sym_count !== 16'd0) $display("FAIL single_count_clear got=%0d exp=0", sym_count);
        else passes++;
`endif
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp;
        logic [1:0]  syms [3];
        logic [1:0]  d;
        syms[0] = 2'b00;
        syms[1] = 2'b11;
        syms[2] = 2'b01;
        enable    = 1'b1;
        sym_data  = syms[0];
        sym_valid = 1'b1;
        step();
        for (int n = 0; n < 96; n++) begin
            d   = syms[n / 32];
            exp = {4'(n), 4'(n + 4), d[1], d[0], 1'b1, (n % 32 == 0), 1'b1, (n % 32 == 31), 1'b0};
            checks++;
            if (obs !== exp) $display("FAIL b2b_sample%0d obs=%h exp=%h", n, obs, exp);
            else passes++;
            if (n % 32 == 0) begin
                if (n / 32 < 2) sym_data = syms[n / 32 + 1];
                else sym_valid = 1'b0;
            end
            step();
        end
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) $display("FAIL b2b_end_idle obs=%h exp=%h", obs, exp);
        else passes++;
`ifdef QPSK_SYM_COUNT_EN
        checks++;
        if (sym_count !== 16'd3) $display("FAIL b2b_sym_count got=%0d exp=3", sym_count);
        else passes++;
`endif
    endtask

    task automatic test_enable_drop;
        logic [14:0] exp;
        clear_underrun = 1'b1;
        enable         = 1'b1;
        sym_data       = 2'b01;
        sym_valid      = 1'b1;
        step();
        clear_underrun = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp = {4'(n), 4'(n + 4), 1'b0, 1'b1, 1'b1, (n == 0), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp) $display("FAIL endrop_sample%0d obs=%h exp=%h", n, obs, exp);
            else passes++;
            if (n == 10) enable = 1'b0;
            step();
        end
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) $display("FAIL endrop_idle obs=%h exp=%h", obs, exp);
        else passes++;
        step();
        checks++;
        if (obs !== exp) $display("FAIL endrop_stay_idle obs=%h exp=%h", obs, exp);
        else passes++;
        sym_valid = 1'b0;
    endtask

    task automatic test_reset_mid_symbol;
        logic [14:0] exp;
        enable    = 1'b1;
        sym_data  = 2'b11;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
        for (int n = 0; n < 17; n++) step();
        exp = {4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) $display("FAIL midrst_sample17 obs=%h exp=%h", obs, exp);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) $display("FAIL midrst_async obs=%h exp=%h", obs, exp);
        else passes++;
        step();
        rst       = 1'b0;
        sym_data  = 2'b00;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
        for (int n = 0; n < 32; n++) begin
            exp = {4'(n), 4'(n + 4), 1'b0, 1'b0, 1'b1, (n == 0), 1'b1, (n == 31), 1'b0};
            checks++;
            if (obs !== exp) $display("FAIL restart_sample%0d obs=%h exp=%h", n, obs, exp);
            else passes++;
            if (n == 31) clear_underrun = 1'b1;
            step();
        end
        clear_underrun = 1'b0;
        exp = {4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) $display("FAIL set_beats_clear obs=%h exp=%h", obs, exp);
        else passes++;
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) $display("FAIL lone_clear got=%b exp=0", underrun);
        else passes++;
`ifdef QPSK_SYM_COUNT_EN
        checks++;
        if (sym_count !== 16'd0) $display("FAIL lone_clear_count got=%0d exp=0", sym_count);
        else passes++;
`endif
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        clear_underrun = 1'b0;
        sym_data       = 2'b00;
        sym_valid      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_symbol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
